// File: rtl/enigma_stepper_core.sv
// Multi-rotor Enigma core with odometer/double-step stepping and reflector B, one symbol in flight.
// Optional plugboard behind `ENIGMA_PLUGBOARD_EN`; out_valid rises 2*NUM_ROTORS+2 edges after accept.
module enigma_stepper_core #(
   parameter int NUM_ROTORS = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cfg_load,
   input  logic [NUM_ROTORS*5-1:0] cfg_pos,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [4:0]              in_sym,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [4:0]              out_sym,
   output logic [NUM_ROTORS*5-1:0] pos
`ifdef ENIGMA_PLUGBOARD_EN
   ,
   input  logic                    plug_we,
   input  logic [4:0]              plug_a,
   input  logic [4:0]              plug_b
`endif
);
   localparam int ALPHA = 26;
   localparam int SYM_W = 5;
   localparam logic [2:0] LAST = 3'(NUM_ROTORS - 1);

   localparam logic [207:0] W_I   = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
   localparam logic [207:0] W_II  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
   localparam logic [207:0] W_III = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
   localparam logic [207:0] W_IV  = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
   localparam logic [207:0] W_V   = "VZBRGITYUPSDNHLXAWMJQOFECK";
   localparam logic [207:0] REF_B = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

   typedef enum logic [2:0] {IDLE, STEP, FWD, REFL, BACK, OUT} state_t;

   function automatic logic [SYM_W-1:0] add26(input logic [SYM_W-1:0] a, input logic [SYM_W-1:0] b);
      logic [SYM_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= 6'(ALPHA)) s = s - 6'(ALPHA);
      return s[SYM_W-1:0];
   endfunction

   function automatic logic [SYM_W-1:0] sub26(input logic [SYM_W-1:0] a, input logic [SYM_W-1:0] b);
      logic [SYM_W:0] s;
      if (a >= b) s = {1'b0, a} - {1'b0, b};
      else        s = {1'b0, a} + 6'(ALPHA) - {1'b0, b};
      return s[SYM_W-1:0];
   endfunction

   // Letter i of a 26-character table, leftmost character is entry 0.
   function automatic logic [SYM_W-1:0] tab(input logic [207:0] s, input logic [SYM_W-1:0] i);
      logic [7:0] c;
      logic [7:0] v;
      c = 8'h41;
      for (int j = 0; j < ALPHA; j++)
         if (i == 5'(j)) c = s[8*(25-j) +: 8];
      v = c - 8'h41;
      return v[SYM_W-1:0];
   endfunction

   function automatic logic [207:0] wstr(input logic [2:0] t);
      case (t)
         3'd0:    return W_I;
         3'd1:    return W_II;
         3'd2:    return W_III;
         3'd3:    return W_IV;
         default: return W_V;
      endcase
   endfunction

   function automatic logic [2:0] rtype(input logic [2:0] k);
      case (k)
         3'd0:    return 3'd2;
         3'd1:    return 3'd1;
         3'd2:    return 3'd0;
         3'd3:    return 3'd3;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic [SYM_W-1:0] notch(input logic [2:0] t);
      case (t)
         3'd0:    return 5'd16;
         3'd1:    return 5'd4;
         3'd2:    return 5'd21;
         3'd3:    return 5'd9;
         default: return 5'd25;
      endcase
   endfunction

   function automatic logic [SYM_W-1:0] winv(input logic [2:0] t, input logic [SYM_W-1:0] x);
      logic [SYM_W-1:0] r;
      r = '0;
      for (int j = 0; j < ALPHA; j++)
         if (tab(wstr(t), 5'(j)) == x) r = 5'(j);
      return r;
   endfunction

   state_t            state;
   logic [2:0]        idx;
   logic [SYM_W-1:0]  d;
   logic              pass;
   logic [SYM_W-1:0]  rp [NUM_ROTORS];
   logic [SYM_W-1:0]  step_pos [NUM_ROTORS];
   logic [NUM_ROTORS-1:0] at_n, st;
   logic [SYM_W-1:0]  p, fwd_d, bwd_d, refl_d, sw_in, sw_out;
   logic [2:0]        cur_t;

   assign in_ready = (state == IDLE) && !cfg_load;

   always_comb begin
      pos = '0;
      for (int k = 0; k < NUM_ROTORS; k++) pos[k*5 +: 5] = rp[k];
   end

   // Stepping decisions all use pre-step positions, which gives the double-step.
   always_comb begin
      at_n = '0;
      st   = '0;
      st[0] = 1'b1;
      for (int k = 0; k < NUM_ROTORS; k++) at_n[k] = (rp[k] == notch(rtype(3'(k))));
      for (int k = 0; k <= NUM_ROTORS - 2; k++) if (at_n[k]) st[k+1] = 1'b1;
      for (int k = 1; k <= NUM_ROTORS - 2; k++) if (at_n[k]) st[k] = 1'b1;
      for (int k = 0; k < NUM_ROTORS; k++) step_pos[k] = st[k] ? add26(rp[k], 5'd1) : rp[k];
   end

   always_comb begin
      p = '0;
      for (int k = 0; k < NUM_ROTORS; k++) if (idx == 3'(k)) p = rp[k];
      cur_t  = rtype(idx);
      fwd_d  = sub26(tab(wstr(cur_t), add26(d, p)), p);
      bwd_d  = sub26(winv(cur_t, add26(d, p)), p);
      refl_d = tab(REF_B, d);
   end

`ifdef ENIGMA_PLUGBOARD_EN
   logic [SYM_W-1:0] plug [ALPHA];
   assign sw_in  = plug[in_sym];
   assign sw_out = plug[bwd_d];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ALPHA; i++) plug[i] <= 5'(i);
      end else if (state == IDLE && plug_we && plug_a < 5'(ALPHA) && plug_b < 5'(ALPHA)) begin
         // Old partners revert first; the new pair's writes come last and win.
         if (plug_a != plug_b) begin
            plug[plug[plug_a]] <= plug[plug_a];
            plug[plug[plug_b]] <= plug[plug_b];
            plug[plug_a]       <= plug_b;
            plug[plug_b]       <= plug_a;
         end else begin
            plug[plug[plug_a]] <= plug[plug_a];
            plug[plug_a]       <= plug_a;
         end
      end
   end
`else
   assign sw_in  = in_sym;
   assign sw_out = bwd_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         d         <= '0;
         pass      <= 1'b0;
         out_valid <= 1'b0;
         out_sym   <= '0;
         for (int k = 0; k < NUM_ROTORS; k++) rp[k] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cfg_load) begin
                  for (int k = 0; k < NUM_ROTORS; k++)
                     rp[k] <= (cfg_pos[k*5 +: 5] >= 5'(ALPHA)) ? 5'd0 : cfg_pos[k*5 +: 5];
               end else if (in_valid) begin
                  pass  <= (in_sym >= 5'(ALPHA));
                  d     <= (in_sym >= 5'(ALPHA)) ? in_sym : sw_in;
                  state <= STEP;
               end
            end
            STEP: begin
               if (!pass) for (int k = 0; k < NUM_ROTORS; k++) rp[k] <= step_pos[k];
               idx   <= '0;
               state <= FWD;
            end
            FWD: begin
               if (!pass) d <= fwd_d;
               if (idx == LAST) state <= REFL;
               else             idx   <= idx + 3'd1;
            end
            REFL: begin
               if (!pass) d <= refl_d;
               idx   <= LAST;
               state <= BACK;
            end
            BACK: begin
               if (!pass) d <= bwd_d;
               if (idx == 3'd0) begin
                  out_sym   <= pass ? d : sw_out;
                  out_valid <= 1'b1;
                  state     <= OUT;
               end else begin
                  idx <= idx - 3'd1;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_enigma_stepper_core.sv
// Bench for enigma_stepper_core: known vectors, double-step, backpressure, pass-through, reset, random traffic.
module tb_enigma_stepper_core;
   localparam int N = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, cfg_load, in_valid, in_ready, out_valid, out_ready;
   logic [N*5-1:0] cfg_pos, pos;
   logic [4:0] in_sym, out_sym;
`ifdef ENIGMA_PLUGBOARD_EN
   logic plug_we;
   logic [4:0] plug_a, plug_b;
`endif

   int checks = 0;
   int errors = 0;

   enigma_stepper_core #(.NUM_ROTORS(N)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pos(cfg_pos),
      .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
      .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym), .pos(pos)
`ifdef ENIGMA_PLUGBOARD_EN
      , .plug_we(plug_we), .plug_a(plug_a), .plug_b(plug_b)
`endif
   );

   // Reference model: textbook Enigma arithmetic on integer tables.
   string wires[5] = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ", "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                       "BDFHJLCPRTXVZNYEIWGAKMUSQO", "ESOVPZJAYQUIRHXLNFTGKDCMWB",
                       "VZBRGITYUPSDNHLXAWMJQOFECK"};
   string refl = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
   string notches = "QEVJZ";
   int rtype[5] = '{2, 1, 0, 3, 4};
   int wf[5][26];
   int wi[5][26];
   int rf[26];
   int mpos[N];
   int mplug[26];

   function automatic void build();
      for (int t = 0; t < 5; t++)
         for (int i = 0; i < 26; i++) begin
            wf[t][i] = int'(wires[t][i]) - 65;
            wi[t][wf[t][i]] = i;
         end
      for (int i = 0; i < 26; i++) begin
         rf[i] = int'(refl[i]) - 65;
         mplug[i] = i;
      end
      for (int k = 0; k < N; k++) mpos[k] = 0;
   endfunction

   function automatic int notch_of(int k);
      return int'(notches[rtype[k]]) - 65;
   endfunction

   function automatic void m_step();
      int st[N];
      for (int k = 0; k < N; k++) st[k] = 0;
      st[0] = 1;
      for (int k = 0; k < N - 1; k++) if (mpos[k] == notch_of(k)) st[k+1] = 1;
      for (int k = 1; k < N - 1; k++) if (mpos[k] == notch_of(k)) st[k] = 1;
      for (int k = 0; k < N; k++) mpos[k] = (mpos[k] + st[k]) % 26;
   endfunction

   function automatic int m_enc(int s);
      int d, p, t;
      if (s >= 26) return s;
      m_step();
      d = mplug[s];
      for (int k = 0; k < N; k++) begin
         p = mpos[k]; t = rtype[k];
         d = (wf[t][(d + p) % 26] - p + 26) % 26;
      end
      d = rf[d];
      for (int k = N - 1; k >= 0; k--) begin
         p = mpos[k]; t = rtype[k];
         d = (wi[t][(d + p) % 26] - p + 26) % 26;
      end
      return mplug[d];
   endfunction

   function automatic logic [N*5-1:0] m_pos_vec();
      logic [N*5-1:0] v;
      for (int k = 0; k < N; k++) v[k*5 +: 5] = 5'(mpos[k]);
      return v;
   endfunction

   function automatic void m_reset();
      for (int k = 0; k < N; k++) mpos[k] = 0;
      for (int i = 0; i < 26; i++) mplug[i] = i;
   endfunction

   task automatic do_cfg(input logic [N*5-1:0] v);
      @(negedge clk);
      cfg_load = 1'b1; cfg_pos = v;
      @(posedge clk); #1;
      cfg_load = 1'b0;
      for (int k = 0; k < N; k++) mpos[k] = (int'(v[k*5 +: 5]) >= 26) ? 0 : int'(v[k*5 +: 5]);
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      if (out_valid !== 1'b1) begin
         checks++; errors++;
         $display("FAIL out_valid_timeout got %b want 1", out_valid);
      end
   endtask

   task automatic run_sym(input int s, output int o, output int lat);
      int w;
      @(negedge clk);
      w = 0;
      while (in_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
      if (in_ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL accept_timeout in_ready %b want 1", in_ready);
      end
      in_sym = 5'(s); in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_out(lat);
      o = int'(out_sym);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cfg_load = 1'b0; cfg_pos = '0; in_valid = 1'b0; in_sym = '0; out_ready = 1'b0;
`ifdef ENIGMA_PLUGBOARD_EN
      plug_we = 1'b0; plug_a = '0; plug_b = '0;
`endif
      build();
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (out_sym !== 5'd0) begin errors++; $display("FAIL reset_out_sym got %0d want 0", out_sym); end
      checks++; if (pos !== '0) begin errors++; $display("FAIL reset_pos got %h want 0", pos); end
   endtask

   task automatic test_known(input string tag);
      int exp_o[5] = '{1, 3, 25, 6, 14};
      int o, lat;
      for (int i = 0; i < 5; i++) begin
         run_sym(0, o, lat);
         void'(m_enc(0));
         checks++;
         if (o != exp_o[i]) begin errors++; $display("FAIL %s_sym%0d got %0d want %0d", tag, i, o, exp_o[i]); end
         if (i == 0) begin
            checks++;
            if (lat != 2*N + 2) begin errors++; $display("FAIL %s_latency got %0d want %0d", tag, lat, 2*N+2); end
         end
      end
      checks++;
      if (pos !== {5'd0, 5'd0, 5'd5}) begin errors++; $display("FAIL %s_final_pos got %h want %h", tag, pos, {5'd0, 5'd0, 5'd5}); end
   endtask

   task automatic test_double_step();
      logic [N*5-1:0] exp_p[3] = '{{5'd0, 5'd3, 5'd21}, {5'd0, 5'd4, 5'd22}, {5'd1, 5'd5, 5'd23}};
      int o, lat, e;
      do_cfg({5'd0, 5'd3, 5'd20});
      for (int i = 0; i < 3; i++) begin
         int s = $urandom_range(0, 25);
         e = m_enc(s);
         run_sym(s, o, lat);
         checks++;
         if (pos !== exp_p[i]) begin errors++; $display("FAIL dstep_pos%0d got %h want %h", i, pos, exp_p[i]); end
         checks++;
         if (o != e) begin errors++; $display("FAIL dstep_sym%0d got %0d want %0d", i, o, e); end
      end
   endtask

   task automatic test_backpressure();
      logic [4:0] held;
      logic [N*5-1:0] p0;
      int e1, e2, lat;
      @(negedge clk);
      in_sym = 5'd7; in_valid = 1'b1; out_ready = 1'b0;
      e1 = m_enc(7);
      @(posedge clk); #1;
      in_sym = 5'd9;
      wait_out(lat);
      held = out_sym; p0 = pos;
      checks++;
      if (held != 5'(e1)) begin errors++; $display("FAIL bp_first_sym got %0d want %0d", held, e1); end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || out_sym !== held || in_ready !== 1'b0 || pos !== p0) begin
            errors++;
            $display("FAIL bp_hold%0d got v=%b s=%0d r=%b p=%h want v=1 s=%0d r=0 p=%h", c, out_valid, out_sym, in_ready, pos, held, p0);
         end
      end
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept in_ready %b want 0", in_ready); end
      in_valid = 1'b0;
      e2 = m_enc(9);
      wait_out(lat);
      checks++;
      if (out_sym !== 5'(e2)) begin errors++; $display("FAIL bp_second_sym got %0d want %0d", out_sym, e2); end
      @(posedge clk); #1;
   endtask

   task automatic test_passthrough();
      logic [N*5-1:0] p0;
      int o, lat;
      p0 = pos;
      run_sym(30, o, lat);
      checks++; if (o != 30) begin errors++; $display("FAIL pass_sym got %0d want 30", o); end
      checks++; if (lat != 2*N + 2) begin errors++; $display("FAIL pass_latency got %0d want %0d", lat, 2*N+2); end
      checks++; if (pos !== p0) begin errors++; $display("FAIL pass_pos got %h want %h", pos, p0); end
   endtask

   task automatic test_cfg();
      int e, lat;
      do_cfg({5'd2, 5'd31, 5'd27});
      checks++;
      if (pos !== {5'd2, 5'd0, 5'd0}) begin errors++; $display("FAIL cfg_clamp got %h want %h", pos, {5'd2, 5'd0, 5'd0}); end
      @(negedge clk);
      in_sym = 5'd4; in_valid = 1'b1; out_ready = 1'b1;
      e = m_enc(4);
      @(posedge clk); #1;
      in_valid = 1'b0; cfg_load = 1'b1; cfg_pos = {5'd9, 5'd9, 5'd9};
      wait_out(lat);
      cfg_load = 1'b0;
      checks++;
      if (out_sym !== 5'(e)) begin errors++; $display("FAIL cfg_busy_sym got %0d want %0d", out_sym, e); end
      @(posedge clk); #1;
      checks++;
      if (pos !== m_pos_vec()) begin errors++; $display("FAIL cfg_busy_ignored got %h want %h", pos, m_pos_vec()); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      in_sym = 5'd0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk); rst_n = 1'b0;
      #1;
      m_reset();
      checks++;
      if (pos !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_sym !== 5'd0) begin
         errors++;
         $display("FAIL rst_mid got p=%h v=%b r=%b s=%0d want 0 0 1 0", pos, out_valid, in_ready, out_sym);
      end
      @(negedge clk); rst_n = 1'b1;
      test_known("rst_known");
   endtask

   task automatic test_random();
      int o, lat, e, s;
      for (int i = 0; i < 40; i++) begin
         if (i % 8 == 0) do_cfg(N*5'($urandom));
         s = ($urandom_range(0, 9) == 0) ? $urandom_range(26, 31) : $urandom_range(0, 25);
         e = m_enc(s);
         run_sym(s, o, lat);
         checks++;
         if (o != e || pos !== m_pos_vec()) begin
            errors++;
            $display("FAIL rand%0d sym %0d got o=%0d p=%h want o=%0d p=%h", i, s, o, pos, e, m_pos_vec());
         end
      end
   endtask

`ifdef ENIGMA_PLUGBOARD_EN
   task automatic do_plug(input int a, input int b);
      int pa, pb;
      @(negedge clk);
      plug_we = 1'b1; plug_a = 5'(a); plug_b = 5'(b);
      @(posedge clk); #1;
      plug_we = 1'b0;
      if (a < 26 && b < 26) begin
         pa = mplug[a]; pb = mplug[b];
         mplug[pa] = pa; mplug[pb] = pb;
         if (a != b) begin mplug[a] = b; mplug[b] = a; end
      end
   endtask

   task automatic test_plugboard();
      int o, lat, e, s;
      do_cfg('0);
      do_plug(0, 1);
      run_sym(1, o, lat);
      void'(m_enc(1));
      checks++;
      if (o != 0) begin errors++; $display("FAIL plug_ab got %0d want 0", o); end
      for (int i = 0; i < 12; i++) begin
         do_plug($urandom_range(0, 28), $urandom_range(0, 28));
         s = $urandom_range(0, 25);
         e = m_enc(s);
         run_sym(s, o, lat);
         checks++;
         if (o != e) begin errors++; $display("FAIL plug_rand%0d got %0d want %0d", i, o, e); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_known("known");
      test_double_step();
      test_backpressure();
      test_passthrough();
      test_cfg();
      test_reset_mid();
      test_random();
`ifdef ENIGMA_PLUGBOARD_EN
      test_plugboard();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
